// File: rtl/lcd_value_formatter.sv
// lcd_value_formatter
// Converts a 16-bit unsigned value into a two-line 16x2 character-LCD image:
// line 1 "VALOR:" plus a right-aligned, leading-zero-blanked decimal readout,
// line 2 "HEX: 0x" plus four uppercase hex digits. Each cell is a 9-bit
// {RS, ASCII} word. Cell k of a line occupies bits [9k+8:9k].
// Binary-to-BCD conversion is sequential shift-add-3, one bit per clock.

module lcd_value_formatter (
   input  logic         iCLK,
   input  logic         iRST_N,
   input  logic         iSTART,
   input  logic [15:0]  iVALUE,
   output logic         oBUSY,
   output logic         oDONE,
   output logic [143:0] oLINE1,
   output logic [143:0] oLINE2
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_FMT  = 2'd2
   } state_t;

   localparam logic [8:0]  CELL_SPACE = 9'h120;
   localparam logic [47:0] LABEL1     = "VALOR:";
   localparam logic [55:0] LABEL2     = "HEX: 0x";

   // Line 1 image from a 5-digit BCD value; leading zeros in cells 11-14
   // become spaces, cell 15 always carries a digit.
   function automatic logic [143:0] build_line1(input logic [19:0] bcd);
      logic [143:0] line;
      logic [3:0]   dig;
      logic         lead;
      for (int k = 0; k < 16; k++) line[9*k +: 9] = CELL_SPACE;
      for (int k = 0; k < 6; k++)  line[9*k +: 9] = {1'b1, LABEL1[47-8*k -: 8]};
      lead = 1'b1;
      for (int d = 0; d < 5; d++) begin
         dig = bcd[19-4*d -: 4];
         if (dig != 4'd0 || d == 4) lead = 1'b0;
         if (!lead) line[9*(11+d) +: 9] = {1'b1, 8'h30 + {4'h0, dig}};
      end
      return line;
   endfunction

   // Line 2 image: fixed label, four uppercase hex nibbles, trailing spaces.
   function automatic logic [143:0] build_line2(input logic [15:0] value);
      logic [143:0] line;
      logic [3:0]   nib;
      for (int k = 0; k < 16; k++) line[9*k +: 9] = CELL_SPACE;
      for (int k = 0; k < 7; k++)  line[9*k +: 9] = {1'b1, LABEL2[55-8*k -: 8]};
      for (int n = 0; n < 4; n++) begin
         nib = value[15-4*n -: 4];
         line[9*(7+n) +: 9] = (nib < 4'd10) ? {1'b1, 8'h30 + {4'h0, nib}}
                                            : {1'b1, 8'h37 + {4'h0, nib}};
      end
      return line;
   endfunction

   state_t       state, state_nxt;
   logic [15:0]  shift_q;
   logic [15:0]  value_q;
   logic [19:0]  bcd_q;
   logic [4:0]   cnt_q;
   logic [19:0]  bcd_adj;
   logic [35:0]  dd_next;

   // State register; an asynchronous reset aborts any conversion in flight.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values; blocking assignments here would create order races.
      if (!iRST_N) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic: IDLE -> CONV (16 shifts) -> FMT -> IDLE.
   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt; a missing
      // branch would otherwise infer a latch.
      state_nxt = state;
      case (state)
         S_IDLE: if (iSTART) state_nxt = S_CONV;
         S_CONV: if (cnt_q == 5'd15) state_nxt = S_FMT;
         S_FMT:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Add-3 correction on every BCD digit >= 5, ahead of the next shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   assign dd_next = {bcd_adj, shift_q} << 1;
   assign oBUSY   = (state != S_IDLE);

   // Conversion datapath and output image registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         // NOTE: output lines reset to the image of value zero so the display
         // shows a coherent screen straight out of reset.
         shift_q <= '0;
         value_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         oDONE   <= 1'b0;
         oLINE1  <= build_line1(20'd0);
         oLINE2  <= build_line2(16'd0);
      end else begin
         oDONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iSTART) begin
                  shift_q <= iVALUE;
                  value_q <= iVALUE;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            S_CONV: begin
               bcd_q   <= dd_next[35:16];
               shift_q <= dd_next[15:0];
               cnt_q   <= cnt_q + 5'd1;
            end
            S_FMT: begin
               oLINE1 <= build_line1(bcd_q);
               oLINE2 <= build_line2(value_q);
               oDONE  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
